// File: rtl/nios_system_hw_to_sw_capture.sv
`timescale 1ns/1ps
// Avalon-MM input PIO: synchronises hardware inputs into clk, captures selected edges,
// counts edge events and raises a maskable level interrupt to the CPU.
module nios_system_hw_to_sw_capture #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   typedef enum logic {PRIME, RUN} state_e;

   state_e                            state_q;
   logic [2:0]                        primeCnt_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  prev_q;
   logic [WIDTH-1:0]                  mask_q, mask_d;
   logic [WIDTH-1:0]                  edgeCap_q, edgeCap_d;
   logic [15:0]                       count_q, count_d;
   logic [WIDTH-1:0]                  syncVal, evRaw, ev, clr;
   logic                              wrEn, anyEv;
   logic                              unusedWriteBits;

   assign syncVal         = sync_q[SYNC_STAGES-1];
   assign wrEn            = chipselect & ~write_n;
   assign anyEv           = |ev;
   assign unusedWriteBits = ^writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         prev_q <= syncVal;
      end
   end

   // Edges are ignored while priming so reset-zeroed flops cannot fake a rising edge.
   always_comb begin
      case (EDGE_TYPE)
         0:       evRaw = syncVal & ~prev_q;
         1:       evRaw = ~syncVal & prev_q;
         default: evRaw = syncVal ^ prev_q;
      endcase
      ev = (state_q == RUN) ? evRaw : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= PRIME;
         primeCnt_q <= '0;
      end else if (state_q == PRIME) begin
         if (primeCnt_q == 3'(SYNC_STAGES)) begin
            state_q <= RUN;
         end else begin
            primeCnt_q <= primeCnt_q + 3'd1;
         end
      end
   end

   // A capture in the same cycle as a clear wins, for both EDGE bits and COUNT.
   always_comb begin
      clr     = '0;
      mask_d  = mask_q;
      count_d = count_q;
      if (wrEn && address == 2'd3) clr = writedata[WIDTH-1:0];
      if (wrEn && address == 2'd2) mask_d = writedata[WIDTH-1:0];
      edgeCap_d = (edgeCap_q & ~clr) | ev;
      if (wrEn && address == 2'd1) begin
         count_d = anyEv ? 16'd1 : 16'd0;
      end else if (anyEv && count_q != 16'hFFFF) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q    <= '0;
         edgeCap_q <= '0;
         count_q   <= '0;
      end else begin
         mask_q    <= mask_d;
         edgeCap_q <= edgeCap_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = syncVal;
         2'd1:    readdata[15:0]      = count_q;
         2'd2:    readdata[WIDTH-1:0] = mask_q;
         default: readdata[WIDTH-1:0] = edgeCap_q;
      endcase
   end

   assign irq = |(edgeCap_q & mask_q);

endmodule
